// File: rtl/l2_mem_req_adapter_if.sv
// Signal bundle between the SoC request/response channels, the adapter and the L2 SRAM wrapper.
// The slave modport is the adapter's view; master is the surrounding interconnect and memory.
interface l2_mem_req_adapter_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [7:0]            req_be;
    logic [63:0]           req_wdata;
    logic [ID_WIDTH-1:0]   req_id;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_we;
    logic [63:0]           rsp_rdata;
    logic [ID_WIDTH-1:0]   rsp_id;

    logic                  mem_csn;
    logic                  mem_wen;
    logic [7:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_add;
    logic [63:0]           mem_wdata;
    logic [63:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, req_id,
        output req_ready,
        output rsp_valid, rsp_we, rsp_rdata, rsp_id,
        input  rsp_ready,
        output mem_csn, mem_wen, mem_be, mem_add, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, req_id,
        input  req_ready,
        input  rsp_valid, rsp_we, rsp_rdata, rsp_id,
        output rsp_ready,
        input  mem_csn, mem_wen, mem_be, mem_add, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/l2_mem_req_adapter.sv
// Turns a valid/ready request stream into single-cycle SRAM accesses and returns responses
// through a credit-protected FIFO with a fall-through path when the FIFO is empty.
module l2_mem_req_adapter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    l2_mem_req_adapter_if.slave  bus_io
);
    localparam int unsigned PtrW = $clog2(RSP_DEPTH);
    localparam int unsigned OccW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned EntW = 1 + ID_WIDTH + 64;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [OccW-1:0] occ_t;
    typedef logic [OccW:0]   cnt_t;

    logic [EntW-1:0]       fifo_q [RSP_DEPTH];
    ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    occ_t                  occ_q, occ_d;
    logic                  inflight_q, infl_we_q;
    logic [ID_WIDTH-1:0]   infl_id_q;

    logic                  req_ready, hs, fifo_empty, push, pop, rsp_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [EntW-1:0]       payload, head, rsp_sel;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(RSP_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Credits count both buffered entries and the access whose data arrives next cycle.
    assign req_ready  = !rst_i && ((cnt_t'(occ_q) + cnt_t'(inflight_q)) < cnt_t'(RSP_DEPTH));
    assign hs         = bus_io.req_valid && req_ready;
    assign req_addr   = bus_io.req_addr;

    assign bus_io.req_ready = req_ready;
    assign bus_io.mem_csn   = !hs;
    assign bus_io.mem_wen   = hs ? !bus_io.req_we : 1'b1;
    assign bus_io.mem_be    = hs ? bus_io.req_be : 8'h00;
    assign bus_io.mem_add   = hs ? req_addr : '0;
    assign bus_io.mem_wdata = hs ? bus_io.req_wdata : 64'd0;

    assign fifo_empty = (occ_q == '0);
    assign payload    = {infl_we_q, infl_id_q, infl_we_q ? 64'd0 : bus_io.mem_rdata};
    assign head       = fifo_q[rd_ptr_q];
    // The inflight payload bypasses the FIFO only when it is empty and consumed at once.
    assign push       = inflight_q && !(fifo_empty && bus_io.rsp_ready);
    assign pop        = !fifo_empty && bus_io.rsp_ready;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !pop) begin
            occ_d = occ_q + occ_t'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - occ_t'(1);
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_comb begin
        rsp_valid = 1'b0;
        rsp_sel   = '0;
        if (!fifo_empty) begin
            rsp_valid = 1'b1;
            rsp_sel   = head;
        end else if (inflight_q) begin
            rsp_valid = 1'b1;
            rsp_sel   = payload;
        end
    end

    assign bus_io.rsp_valid = rsp_valid;
    assign {bus_io.rsp_we, bus_io.rsp_id, bus_io.rsp_rdata} = rsp_sel;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            infl_we_q  <= 1'b0;
            infl_id_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= hs;
            if (hs) begin
                infl_we_q <= bus_io.req_we;
                infl_id_q <= bus_io.req_id;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= payload;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && occ_q == occ_t'(RSP_DEPTH)));
endmodule

// File: tb/tb_l2_mem_req_adapter.sv
// Scoreboard bench: the driver queues expected responses from a word-level memory model,
// a negedge monitor checks credits, SRAM strobes and responses against that queue.
module tb_l2_mem_req_adapter;
    localparam int unsigned AW    = 15;
    localparam int unsigned IW    = 4;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic          we;
        logic [IW-1:0] id;
        logic [63:0]   data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_mem_req_adapter_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    l2_mem_req_adapter #(
        .ADDR_WIDTH(AW),
        .ID_WIDTH  (IW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    rsp_t          exp_q[$];
    logic [63:0]   sram    [int unsigned];
    logic [63:0]   ref_mem [int unsigned];
    int            checks = 0;
    int            errors = 0;
    bit            rr_rand = 1'b0;
    logic [63:0]   last_rdata = '0;
    logic [IW-1:0] last_id = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 64'd0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
        return m;
    endfunction

    // SRAM macro: write on the access edge, read data valid the following cycle.
    always @(posedge clk) begin
        logic [63:0] mask;
        logic [63:0] old;
        if (bus.mem_csn === 1'b0) begin
            old = sram.exists(int'(bus.mem_add)) ? sram[int'(bus.mem_add)] : 64'd0;
            if (bus.mem_wen === 1'b0) begin
                mask = '0;
                for (int b = 0; b < 8; b++) if (bus.mem_be[b]) mask[8*b +: 8] = 8'hFF;
                sram[int'(bus.mem_add)] = (old & ~mask) | (bus.mem_wdata & mask);
            end else begin
                bus.mem_rdata <= old;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rr_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pending expected responses equal occupancy plus inflight.
    always @(negedge clk) begin
        rsp_t e;
        logic hs;
        if (!rst) begin
            hs = bus.req_valid && bus.req_ready;
            chk("req_ready_credit", 64'(bus.req_ready), 64'(exp_q.size() < int'(DEPTH)));
            chk("rsp_valid_pending", 64'(bus.rsp_valid), 64'(exp_q.size() > 0));
            chk("mem_csn", 64'(bus.mem_csn), 64'(!hs));
            if (!hs) begin
                chk("mem_idle_wen", 64'(bus.mem_wen), 64'd1);
                chk("mem_idle_add_be", {41'd0, bus.mem_be, bus.mem_add}, 64'd0);
                chk("mem_idle_wdata", bus.mem_wdata, 64'd0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d expected no response", bus.rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_we", 64'(bus.rsp_we), 64'(e.we));
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("rsp_rdata", bus.rsp_rdata, e.data);
                    last_rdata = bus.rsp_rdata;
                    last_id    = bus.rsp_id;
                end
            end
        end
    end

    task automatic idle_req();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_be    = '0;
        bus.req_wdata = '0;
        bus.req_id    = '0;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [7:0] be,
                         input logic [63:0] data, input logic [IW-1:0] id, output int waited);
        bit   acc;
        rsp_t e;
        acc    = 1'b0;
        waited = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = data;
        bus.req_id    = id;
        while (!acc && waited <= 50) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = 1'b1;
                chk("mem_wen_hs", 64'(bus.mem_wen), 64'(!we));
                chk("mem_add_hs", 64'(bus.mem_add), 64'(addr));
                chk("mem_be_hs", 64'(bus.mem_be), 64'(be));
                chk("mem_wdata_hs", bus.mem_wdata, data);
            end else begin
                waited++;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got no handshake expected one within 50 cycles");
        end
        @(posedge clk);
        if (acc) begin
            e.we = we;
            e.id = id;
            if (we) begin
                ref_mem[int'(addr)] = merge(ref_rd(addr), data, be);
                e.data = 64'd0;
            end else begin
                e.data = ref_rd(addr);
            end
            exp_q.push_back(e);
        end
        #1;
        idle_req();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 15'h1234;
        bus.req_be    = 8'hFF;
        bus.req_wdata = 64'h1;
        bus.req_id    = 4'h5;
        bus.rsp_ready = 1'b1;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_mem_csn", 64'(bus.mem_csn), 64'd1);
        chk("rst_mem_wen", 64'(bus.mem_wen), 64'd1);
        chk("rst_rsp_we_id", {59'd0, bus.rsp_we, bus.rsp_id}, 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_mem_add_be", {41'd0, bus.mem_be, bus.mem_add}, 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        idle_req();
        @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back through the fall-through path.
        issue(1'b1, 15'd5, 8'hFF, 64'hDEAD_BEEF_0123_4567, 4'd3, w);
        chk("first_accept_wait", 64'(w), 64'd0);
        issue(1'b0, 15'd5, 8'hFF, 64'd0, 4'd7, w);
        drain(10);
        chk("single_read_data", last_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("single_read_id", 64'(last_id), 64'd7);

        // Back-to-back at full throughput.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, AW'(i), 8'hFF, {$urandom, $urandom}, IW'(i), w);
        end
        drain(10);
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, AW'(i), 8'hFF, 64'd0, IW'(i), w);
            chk("b2b_no_wait", 64'(w), 64'd0);
        end
        drain(10);

        // Backpressure: only DEPTH accepted until the consumer drains.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 15'd5, 8'hFF, 64'd0, 4'd1, w);
        issue(1'b0, 15'd0, 8'hFF, 64'd0, 4'd2, w);
        fork
            begin
                int w3;
                issue(1'b0, 15'd1, 8'hFF, 64'd0, 4'd3, w3);
                chk("bp_third_blocked", 64'(w3 >= 5), 64'd1);
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        issue(1'b0, 15'd2, 8'hFF, 64'd0, 4'd4, w);
        drain(10);

        // Partial write over zero.
        issue(1'b1, 15'd9, 8'hFF, 64'd0, 4'd8, w);
        issue(1'b1, 15'd9, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 4'd9, w);
        drain(10);
        chk("partial_ack_rdata", last_rdata, 64'd0);
        issue(1'b0, 15'd9, 8'hFF, 64'd0, 4'd10, w);
        drain(10);
        chk("partial_read", last_rdata, 64'h0000_0000_FFFF_FFFF);

        // Simultaneous push and pop with one buffered entry.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 15'd3, 8'hFF, 64'd0, 4'd11, w);
        issue(1'b0, 15'd4, 8'hFF, 64'd0, 4'd12, w);
        bus.rsp_ready = 1'b1;
        drain(10);
        chk("pushpop_last_id", 64'(last_id), 64'd12);

        // Reset with one buffered and one inflight response.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 15'd6, 8'hFF, 64'd0, 4'd13, w);
        issue(1'b0, 15'd7, 8'hFF, 64'd0, 4'd14, w);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_rsp_fields", {59'd0, bus.rsp_we, bus.rsp_id}, 64'd0);
        chk("mid_rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("mid_rst_mem_csn", 64'(bus.mem_csn), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        issue(1'b1, 15'd5, 8'hFF, 64'h1122_3344_5566_7788, 4'd1, w);
        issue(1'b0, 15'd5, 8'hFF, 64'd0, 4'd2, w);
        drain(10);
        chk("post_rst_read", last_rdata, 64'h1122_3344_5566_7788);

        // Randomized traffic with random consumer backpressure.
        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 8'($urandom),
                  {$urandom, $urandom}, IW'($urandom), w);
        end
        rr_rand = 1'b0;
        @(posedge clk);
        #2 bus.rsp_ready = 1'b1;
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
